// File: rtl/aes256_key_expand.sv
// aes256_key_expand: AES-256 key schedule, one 32-bit word per clock into a 60-word round-key array
module aes256_key_expand (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [255:0] i_key_in,
  input  logic         i_key_valid,
  input  logic [3:0]   i_rk_idx,
  output logic [127:0] o_rk_out,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_keys_valid
);
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int k = 0; k < 8; k++) begin
      p = b[k] ? p ^ x : p;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  // S-box as GF(2^8) inverse (a^254) followed by the affine transform
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] r;
    r = a;
    for (int k = 0; k < 6; k++) r = gmul(gmul(r, r), a);
    r = gmul(r, r);
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction
  logic [31:0] r_w [0:59];
  logic [5:0]  r_i;
  logic        r_busy, r_done, r_kv;
  logic [31:0] w_prev, w_back, w_rot, w_sin, w_sub, w_temp, w_new;
  logic [7:0]  w_rcon;
  logic [5:0]  w_base;
  always_comb begin
    w_prev = r_w[r_i - 6'd1];
    w_back = r_w[r_i - 6'd8];
    w_rot  = {w_prev[23:0], w_prev[31:24]};
    w_sin  = r_i[2:0] == 3'd0 ? w_rot : w_prev;
    w_rcon = 8'h01 << (r_i[5:3] - 3'd1);
    w_temp = r_i[2:0] == 3'd0 ? w_sub ^ {w_rcon, 24'h0} : r_i[2:0] == 3'd4 ? w_sub : w_prev;
    w_new  = w_back ^ w_temp;
    w_base = {i_rk_idx, 2'b00};
    o_rk_out = &i_rk_idx ? '0 : {r_w[w_base], r_w[w_base + 6'd1], r_w[w_base + 6'd2], r_w[w_base + 6'd3]};
  end
  genvar g;
  for (g = 0; g < 4; g++) begin : g_sbox
    assign w_sub[8*g +: 8] = sbox(w_sin[8*g +: 8]);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < 60; j++) r_w[j] <= '0;
      r_i    <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_kv   <= 1'b0;
    end else if (r_busy) begin
      r_w[r_i] <= w_new;
      r_i      <= r_i == 6'd59 ? r_i : r_i + 6'd1;
      r_busy   <= r_i != 6'd59;
      r_done   <= r_i == 6'd59;
      r_kv     <= r_i == 6'd59;
    end else begin
      r_done <= 1'b0;
      if (i_key_valid) begin
        for (int j = 0; j < 8; j++) r_w[j] <= i_key_in[255 - 32*j -: 32];
        r_i    <= 6'd8;
        r_busy <= 1'b1;
        r_kv   <= 1'b0;
      end
    end
  end
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_keys_valid = r_kv;
endmodule
